// File: rtl/zii_slot_ctrl.sv
// Zorro II slot access controller: decodes CPU cycles against the AutoConfig bases and
// sequences RAM select, IDE/ROM chip selects, PIO strobes and DTACK on C7M.
module zii_slot_ctrl #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int RAM_WAIT   = 0
) (
  input  logic       C7M,
  input  logic       RESET,
  input  logic       AS_CPU_n,
  input  logic       DS_n,
  input  logic       RW_n,
  input  logic [7:0] A_HIGH,
  input  logic [3:0] A_MID,
  input  logic       JP2,
  input  logic [2:0] BASE_RAM,
  input  logic [7:0] BASE_IDE,
  input  logic       RAM_CONFIGURED_n,
  input  logic       IDE_CONFIGURED_n,
  output logic       RAM_SEL_n,
  output logic       ROM_CS_n,
  output logic       IDE_CS0_n,
  output logic       IDE_CS1_n,
  output logic       IDE_IOR_n,
  output logic       IDE_IOW_n,
  output logic       DTACK_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_RAM, S_SETUP, S_STROBE, S_HOLD, S_DONE, S_IGNORE
  } state_t;

  typedef enum logic [1:0] {T_RAM, T_ROM, T_CS0, T_CS1} tgt_t;

  logic   as_m_q, as_s_q, ds_m_q, ds_s_q;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  tgt_t   tgt_q, tgt_d;
  logic   wr_q, wr_d;
  logic   ram_sel_d, rom_cs_d, cs0_d, cs1_d, ior_d, iow_d, dtack_d;

  // 4-bit compare so a window near the top of the map does not wrap to 0
  logic [3:0] a_blk, ram_lo, ram_hi;
  logic       ram_hit, ide_hit, busy;

  assign a_blk   = {1'b0, A_HIGH[7:5]};
  assign ram_lo  = {1'b0, BASE_RAM};
  assign ram_hi  = ram_lo + (JP2 ? 4'd4 : 4'd2);
  assign ram_hit = !RAM_CONFIGURED_n && (a_blk >= ram_lo) && (a_blk < ram_hi);
  assign ide_hit = !IDE_CONFIGURED_n && (A_HIGH == BASE_IDE);
  assign busy    = state_q inside {S_RAM, S_SETUP, S_STROBE, S_HOLD};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    wr_d    = wr_q;
    if (busy && as_s_q) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (!as_s_q) begin
          wr_d = !RW_n;
          if (ram_hit) begin
            state_d = S_RAM;
            cnt_d   = 3'(RAM_WAIT);
            tgt_d   = T_RAM;
          end else if (ide_hit) begin
            state_d = S_SETUP;
            cnt_d   = 3'(SETUP_CYC - 1);
            tgt_d   = A_MID[3] ? T_ROM : (A_MID[0] ? T_CS1 : T_CS0);
          end else begin
            state_d = S_IGNORE;
            cnt_d   = '0;
          end
        end
        S_RAM: begin
          if (cnt_q == 3'd0) state_d = S_DONE;
          else cnt_d = cnt_q - 3'd1;
        end
        // counter parks at zero while DS is late, so SETUP stretches per cycle
        S_SETUP: begin
          if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
          else if (!ds_s_q) begin
            state_d = S_STROBE;
            cnt_d   = 3'(STROBE_CYC - 1);
          end
        end
        S_STROBE: begin
          if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
          else if (wr_q) begin
            state_d = S_HOLD;
            cnt_d   = 3'(HOLD_CYC - 1);
          end else begin
            state_d = S_DONE;
          end
        end
        S_HOLD: begin
          if (cnt_q == 3'd0) state_d = S_DONE;
          else cnt_d = cnt_q - 3'd1;
        end
        S_DONE, S_IGNORE: if (as_s_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it
  logic cs_on, strb_on, ide_tgt;
  always_comb begin
    cs_on     = (state_d inside {S_SETUP, S_STROBE, S_HOLD}) || (state_d == S_DONE && !wr_d);
    strb_on   = (state_d == S_STROBE) || (state_d == S_DONE && !wr_d);
    ide_tgt   = (tgt_d == T_CS0) || (tgt_d == T_CS1);
    ram_sel_d = !(tgt_d == T_RAM && (state_d inside {S_RAM, S_DONE}));
    rom_cs_d  = !(strb_on && tgt_d == T_ROM && !wr_d);
    cs0_d     = !(cs_on && tgt_d == T_CS0);
    cs1_d     = !(cs_on && tgt_d == T_CS1);
    ior_d     = !(strb_on && ide_tgt && !wr_d);
    iow_d     = !(state_d == S_STROBE && ide_tgt && wr_d);
    dtack_d   = !(state_d == S_DONE);
  end

  always_ff @(posedge C7M) begin
    if (RESET) begin
      as_m_q    <= 1'b1;
      as_s_q    <= 1'b1;
      ds_m_q    <= 1'b1;
      ds_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tgt_q     <= T_RAM;
      wr_q      <= 1'b0;
      RAM_SEL_n <= 1'b1;
      ROM_CS_n  <= 1'b1;
      IDE_CS0_n <= 1'b1;
      IDE_CS1_n <= 1'b1;
      IDE_IOR_n <= 1'b1;
      IDE_IOW_n <= 1'b1;
      DTACK_n   <= 1'b1;
    end else begin
      as_m_q    <= AS_CPU_n;
      as_s_q    <= as_m_q;
      ds_m_q    <= DS_n;
      ds_s_q    <= ds_m_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      wr_q      <= wr_d;
      RAM_SEL_n <= ram_sel_d;
      ROM_CS_n  <= rom_cs_d;
      IDE_CS0_n <= cs0_d;
      IDE_CS1_n <= cs1_d;
      IDE_IOR_n <= ior_d;
      IDE_IOW_n <= iow_d;
      DTACK_n   <= dtack_d;
    end
  end

endmodule

// File: tb/tb_zii_slot_ctrl.sv
// Scoreboarded bench for zii_slot_ctrl: per-edge expected output vectors are queued per
// transaction and compared from the first edge the DUT leaves the idle pattern.
module tb_zii_slot_ctrl;

  logic       C7M = 1'b0;
  logic       RESET, AS_CPU_n, DS_n, RW_n, JP2;
  logic [7:0] A_HIGH, BASE_IDE;
  logic [3:0] A_MID;
  logic [2:0] BASE_RAM;
  logic       RAM_CONFIGURED_n, IDE_CONFIGURED_n;
  logic       RAM_SEL_n, ROM_CS_n, IDE_CS0_n, IDE_CS1_n, IDE_IOR_n, IDE_IOW_n, DTACK_n;

  zii_slot_ctrl #(.SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1), .RAM_WAIT(0)) dut (
    .C7M(C7M), .RESET(RESET), .AS_CPU_n(AS_CPU_n), .DS_n(DS_n), .RW_n(RW_n),
    .A_HIGH(A_HIGH), .A_MID(A_MID), .JP2(JP2), .BASE_RAM(BASE_RAM), .BASE_IDE(BASE_IDE),
    .RAM_CONFIGURED_n(RAM_CONFIGURED_n), .IDE_CONFIGURED_n(IDE_CONFIGURED_n),
    .RAM_SEL_n(RAM_SEL_n), .ROM_CS_n(ROM_CS_n), .IDE_CS0_n(IDE_CS0_n), .IDE_CS1_n(IDE_CS1_n),
    .IDE_IOR_n(IDE_IOR_n), .IDE_IOW_n(IDE_IOW_n), .DTACK_n(DTACK_n)
  );

  always #5 C7M = ~C7M;

  // Vector order: RAM_SEL, ROM_CS, CS0, CS1, IOR, IOW, DTACK (all active low)
  localparam logic [6:0] IDLE_V = 7'h7F;
  logic [6:0] obs;
  assign obs = {RAM_SEL_n, ROM_CS_n, IDE_CS0_n, IDE_CS1_n, IDE_IOR_n, IDE_IOW_n, DTACK_n};

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int ds_at = 0;
  int rise_at = 0;
  logic [6:0] exp_q[$];

  function automatic logic [6:0] v(input bit ram, rom, cs0, cs1, ior, iow, dt);
    return ~{ram, rom, cs0, cs1, ior, iow, dt};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge C7M);
    #1;
    edge_cnt++;
    if (ds_at != 0 && edge_cnt == ds_at) DS_n = 1'b0;
    if (rise_at != 0 && edge_cnt == rise_at) begin
      AS_CPU_n = 1'b1;
      DS_n     = 1'b1;
    end
  endtask

  task automatic start_cycle(input logic [7:0] ah, input logic [3:0] am, input logic rw,
                             input bit ds_low);
    A_HIGH   = ah;
    A_MID    = am;
    RW_n     = rw;
    AS_CPU_n = 1'b0;
    if (ds_low) DS_n = 1'b0;
    edge_cnt = 0;
  endtask

  task automatic run_trace(input string tag, input bit chk_lat);
    int lat;
    bit ok;
    bit first;
    logic [6:0] e;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      lat++;
      if (obs !== IDLE_V) ok = 1'b1;
    end
    check({tag, "_start"}, 32'(ok), 32'd1);
    if (ok) begin
      if (chk_lat) check({tag, "_lat"}, 32'(lat >= 2 && lat <= 3), 32'd1);
      first = 1'b1;
      while (exp_q.size() > 0) begin
        if (!first) step();
        first = 1'b0;
        e = exp_q.pop_front();
        check(tag, 32'(obs), 32'(e));
      end
    end else begin
      exp_q.delete();
    end
  endtask

  task automatic end_cycle(input string tag);
    AS_CPU_n = 1'b1;
    DS_n     = 1'b1;
    ds_at    = 0;
    rise_at  = 0;
    repeat (3) step();
    check({tag, "_rel"}, 32'(obs), 32'(IDLE_V));
    step();
  endtask

  task automatic ram_hit(input string tag, input logic [7:0] ah, input logic rw);
    start_cycle(ah, 4'h0, rw, 1'b1);
    exp_q.push_back(v(1, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(v(1, 0, 0, 0, 0, 0, 1));
    exp_q.push_back(v(1, 0, 0, 0, 0, 0, 1));
    run_trace(tag, 1'b1);
    end_cycle(tag);
  endtask

  task automatic miss(input string tag, input logic [7:0] ah);
    bit seen;
    start_cycle(ah, 4'h0, 1'b1, 1'b1);
    seen = 1'b0;
    repeat (8) begin
      step();
      if (obs !== IDLE_V) seen = 1'b1;
    end
    check({tag, "_quiet"}, 32'(seen), 32'd0);
    end_cycle(tag);
  endtask

  task automatic push_ide_read(input bit cs1);
    exp_q.push_back(v(0, 0, !cs1, cs1, 0, 0, 0));
    exp_q.push_back(v(0, 0, !cs1, cs1, 1, 0, 0));
    exp_q.push_back(v(0, 0, !cs1, cs1, 1, 0, 0));
    exp_q.push_back(v(0, 0, !cs1, cs1, 1, 0, 1));
    exp_q.push_back(v(0, 0, !cs1, cs1, 1, 0, 1));
  endtask

  initial begin
    RESET = 1'b1; AS_CPU_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1; JP2 = 1'b1;
    A_HIGH = '0; A_MID = '0; BASE_RAM = 3'b001; BASE_IDE = 8'hE9;
    RAM_CONFIGURED_n = 1'b0; IDE_CONFIGURED_n = 1'b0;
    repeat (3) step();
    check("reset", 32'(obs), 32'(IDLE_V));
    RESET = 1'b0;
    repeat (2) step();

    ram_hit("ram_20", 8'h20, 1'b1);
    ram_hit("ram_9F", 8'h9F, 1'b0);
    miss("ram_A0", 8'hA0);
    JP2 = 1'b0;
    ram_hit("ram4_5F", 8'h5F, 1'b1);
    miss("ram4_60", 8'h60);
    JP2 = 1'b1;
    BASE_RAM = 3'b110;
    ram_hit("top_C0", 8'hC0, 1'b1);
    ram_hit("top_FF", 8'hFF, 1'b1);
    ram_hit("prio_E9", 8'hE9, 1'b1);
    miss("nowrap_00", 8'h00);
    BASE_RAM = 3'b001;
    RAM_CONFIGURED_n = 1'b1;
    miss("unconf_20", 8'h20);

    // IDE write, CS0: CS S..S+3, IOW S+1..S+2, DTACK S+4
    start_cycle(8'hE9, 4'h0, 1'b0, 1'b1);
    exp_q.push_back(v(0, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(v(0, 0, 1, 0, 0, 1, 0));
    exp_q.push_back(v(0, 0, 1, 0, 0, 1, 0));
    exp_q.push_back(v(0, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1));
    run_trace("ide_wr", 1'b1);
    end_cycle("ide_wr");

    start_cycle(8'hE9, 4'h1, 1'b1, 1'b1);
    push_ide_read(1'b1);
    run_trace("ide_rd", 1'b1);
    end_cycle("ide_rd");

    // ROM read: nothing visible at S, ROM_CS from S+1, DTACK at S+3
    start_cycle(8'hE9, 4'h8, 1'b1, 1'b1);
    exp_q.push_back(v(0, 1, 0, 0, 0, 0, 0));
    exp_q.push_back(v(0, 1, 0, 0, 0, 0, 0));
    exp_q.push_back(v(0, 1, 0, 0, 0, 0, 1));
    run_trace("rom_rd", 1'b0);
    end_cycle("rom_rd");

    // Late DS: DS_n falls 3 edges after AS_CPU_n, so IOW moves from S+1 to S+3
    ds_at = 3;
    start_cycle(8'hE9, 4'h0, 1'b0, 1'b0);
    exp_q.push_back(v(0, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(v(0, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(v(0, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(v(0, 0, 1, 0, 0, 1, 0));
    exp_q.push_back(v(0, 0, 1, 0, 0, 1, 0));
    exp_q.push_back(v(0, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1));
    run_trace("late_ds", 1'b1);
    end_cycle("late_ds");

    // Abort: AS rises right after S, synchronised high while still in STROBE
    rise_at = 3;
    start_cycle(8'hE9, 4'h0, 1'b1, 1'b1);
    exp_q.push_back(v(0, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(v(0, 0, 1, 0, 1, 0, 0));
    exp_q.push_back(v(0, 0, 1, 0, 1, 0, 0));
    repeat (4) exp_q.push_back(IDLE_V);
    run_trace("abort", 1'b1);
    end_cycle("abort");

    // Reset while in DONE of a read, then a normal RAM cycle
    start_cycle(8'hE9, 4'h0, 1'b1, 1'b1);
    push_ide_read(1'b0);
    run_trace("rst_rd", 1'b1);
    RESET = 1'b1;
    AS_CPU_n = 1'b1;
    DS_n = 1'b1;
    step();
    check("rst_done", 32'(obs), 32'(IDLE_V));
    RESET = 1'b0;
    step();
    RAM_CONFIGURED_n = 1'b0;
    ram_hit("post_rst", 8'h20, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zii_slot_ctrl.md
# zii_slot_ctrl

Zorro II slot access controller that sits directly downstream of the AutoConfig block. It takes the assigned RAM base (`BASE_RAM[7:5]`), the assigned IDE base (`BASE_IDE[7:0]`) and the per-card configured flags, and decodes CPU bus cycles into RAM select, IDE/ROM chip selects and PIO strobes. It runs sequenced setup/strobe/hold timing on `C7M` and returns `DTACK_n` to the CPU.

## Interface
Parameters:
- `SETUP_CYC`, default 1: C7M cycles of CS-to-strobe setup (1..7).
- `STROBE_CYC`, default 2: C7M cycles of IOR/IOW/ROM strobe (1..7).
- `HOLD_CYC`, default 1: C7M cycles of CS hold after IOW release, writes only (1..7).
- `RAM_WAIT`, default 0: extra wait cycles before RAM DTACK (0..6).

Ports:
- `C7M` in 1: system clock; all state changes on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `AS_CPU_n` in 1: CPU address strobe, asynchronous to `C7M`.
- `DS_n` in 1: CPU data strobe, asynchronous to `C7M`.
- `RW_n` in 1: 1 = read.
- `A_HIGH` in 8 [23:16]: address high byte.
- `A_MID` in 4 [15:12]: address bits within the IDE 64K window.
- `JP2` in 1: 1 = 8 MB RAM, 0 = 4 MB RAM.
- `BASE_RAM` in 3 [7:5]: RAM base in 2 MB chunks, from AutoConfig.
- `BASE_IDE` in 8 [7:0]: IDE base A[23:16], from AutoConfig.
- `RAM_CONFIGURED_n` in 1: low = RAM base valid.
- `IDE_CONFIGURED_n` in 1: low = IDE base valid.
- `RAM_SEL_n` out 1: RAM cycle select.
- `ROM_CS_n` out 1: boot ROM select.
- `IDE_CS0_n` out 1: IDE task-file select.
- `IDE_CS1_n` out 1: IDE control-block select.
- `IDE_IOR_n` out 1: IDE read strobe.
- `IDE_IOW_n` out 1: IDE write strobe.
- `DTACK_n` out 1: data acknowledge to CPU.

## Operation
- **Synchronizers.** `AS_CPU_n` and `DS_n` each pass through a 2-flop synchronizer, giving `as_s` and `ds_s`. Both flops reset to 1.
- **Start.** A cycle starts at an edge where the state is IDLE and `as_s`=0. Address, `RW_n` and `JP2` are decoded at that edge.
- **RAM hit.** `RAM_CONFIGURED_n`=0 and `BASE_RAM` ≤ A[23:21] < `BASE_RAM`+N, with N=4 if `JP2`=1 and N=2 if `JP2`=0.
  - Compare with 4-bit arithmetic; there is no wrap past A[23:21]=7.
- **IDE hit.** `IDE_CONFIGURED_n`=0 and `A_HIGH`==`BASE_IDE`. Sub-decode:
  - `A_MID[15]`=1: ROM.
  - else `A_MID[12]`=0: CS0.
  - else: CS1.
- RAM hit takes priority over IDE hit.
- **FSM states:** IDLE, RAM, SETUP, STROBE, HOLD, DONE, IGNORE.
- **IDLE:**
  - No hit → IGNORE.
  - RAM hit → RAM.
  - IDE/ROM hit → SETUP.
- **IGNORE:** all outputs stay inactive; go to IDLE when `as_s`=1.
- **RAM:** `RAM_SEL_n`=0. After `RAM_WAIT` cycles go to DONE.
- **SETUP:** selected CS (or nothing, for ROM) low. Exit to STROBE only when `SETUP_CYC` cycles have elapsed and `ds_s`=0; otherwise stay in SETUP.
- **STROBE:**
  - IDE read: `IDE_IOR_n`=0.
  - IDE write: `IDE_IOW_n`=0.
  - ROM read: `ROM_CS_n`=0.
  - ROM write: no strobe.
  - After `STROBE_CYC` cycles: writes → HOLD, reads → DONE.
- **HOLD:** `IDE_IOW_n`=1, CS stays low; after `HOLD_CYC` cycles → DONE.
- **DONE:** `DTACK_n`=0.
  - Reads keep CS and `IDE_IOR_n`/`ROM_CS_n` asserted so data stays valid.
  - Writes release CS.
  - Go to IDLE when `as_s`=1.
- **IDLE outputs:** all inactive (high).
- **Abort.** `as_s`=1 in RAM, SETUP, STROBE or HOLD → IDLE at that edge; every output goes inactive and no DTACK is issued.
- A single 3-bit counter serves all timed states. It reloads on every state entry.

## Timing
- All outputs are registered.
- Reset values: every output 1; state IDLE; counter 0; synchronizer flops 1. `RESET` overrides everything, including a cycle in progress.
- AS-to-start latency: 2–3 edges after `AS_CPU_n` falls.
- Define edge S as the edge that registers the IDLE→next transition.
- IDE write, defaults, with `ds_s` already low at S+1:
  - CS low at S.
  - `IDE_IOW_n` low at S+1, high at S+3.
  - CS high and `DTACK_n` low at S+4.
- IDE read, defaults:
  - CS low at S.
  - `IDE_IOR_n` low at S+1.
  - `DTACK_n` low at S+3.
  - CS, IOR and DTACK all high at the first edge with `as_s`=1.
- RAM: `RAM_SEL_n` low at S; `DTACK_n` low at S+1+`RAM_WAIT`.
- Late `DS_n`: SETUP extends one edge per cycle `ds_s` stays high.
- Back-to-back cycles: a new start requires one IDLE edge with `as_s`=0 after `as_s` has returned high.

## Test plan
- RAM window:
  - `BASE_RAM`=001, `JP2`=1: `A_HIGH`=0x20 and 0x9F → `RAM_SEL_n` low, `DTACK_n` at S+1; 0xA0 → IGNORE, no DTACK.
  - `JP2`=0: 0x5F hits, 0x60 misses.
- No wrap: `BASE_RAM`=110, `JP2`=1 → 0xC0–0xFF hit, 0x00 misses.
- Unconfigured: `RAM_CONFIGURED_n`=1 → 0x20 misses.
- IDE write, `BASE_IDE`=0xE9, `IDE_CONFIGURED_n`=0, `A_HIGH`=0xE9, `A_MID`=0x0, `RW_n`=0:
  - `IDE_CS0_n` low S..S+3.
  - `IDE_IOW_n` low exactly 2 cycles (S+1..S+2).
  - `DTACK_n` low at S+4.
- IDE read with `A_MID`=0x1: `IDE_CS1_n` and `IDE_IOR_n` held low from S+1 until `AS_CPU_n` rises; `DTACK_n` low at S+3.
- Late DS write: `DS_n` falls 3 cycles after `AS_CPU_n` → `IDE_IOW_n` delayed accordingly and never asserted while `ds_s`=1.
- Abort and reset:
  - `AS_CPU_n` rises during STROBE → all outputs high next edge, no DTACK.
  - `RESET`=1 mid-DONE → all outputs 1 at that edge; a following cycle completes normally.
